// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the load/store adapter.
package mem_lsu_pkg;

    // Adapter FSM encoding.
    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_READ  = 2'd1,
        LSU_WRITE = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_t;

    // Access sizes; encoding 3 is illegal and has no enumerator.
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } lsu_size_t;

    // Request fields captured at acceptance.
    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        is_signed;
        logic [1:0]  offset;
        logic [31:0] wdata;
    } lsu_req_t;

    // Returns 1 for an access that cannot be served as one aligned word
    // access: an odd halfword, an unaligned word, or the illegal size 3.
    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = offset[0];
            SIZE_W:  bad = |offset;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_adapter_if.sv
// Core-side request/response handshake plus the word-wide memory port.
// The slave modport is the adapter; the master modport is its environment
// (the core issuing requests and the memory answering them).
interface mem_lsu_adapter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  in_req_valid;
    logic                  out_req_ready;
    logic                  in_req_write;
    logic [1:0]            in_req_size;
    logic                  in_req_signed;
    logic [ADDR_WIDTH-1:0] in_req_address;
    logic [DATA_WIDTH-1:0] in_req_data;

    logic                  out_resp_valid;
    logic                  in_resp_ready;
    logic [DATA_WIDTH-1:0] out_resp_data;
    logic                  out_resp_exception;

    logic [ADDR_WIDTH-1:0] out_mem_read_address;
    logic [DATA_WIDTH-1:0] in_mem_read_data;
    logic                  out_mem_write_enable;
    logic [ADDR_WIDTH-1:0] out_mem_write_address;
    logic [DATA_WIDTH-1:0] out_mem_write_data;
    logic                  in_mem_read_exception;
    logic                  in_mem_write_exception;

    modport slave (
        input  in_req_valid, in_req_write, in_req_size, in_req_signed,
               in_req_address, in_req_data, in_resp_ready,
               in_mem_read_data, in_mem_read_exception, in_mem_write_exception,
        output out_req_ready, out_resp_valid, out_resp_data, out_resp_exception,
               out_mem_read_address, out_mem_write_enable,
               out_mem_write_address, out_mem_write_data
    );

    modport master (
        output in_req_valid, in_req_write, in_req_size, in_req_signed,
               in_req_address, in_req_data, in_resp_ready,
               in_mem_read_data, in_mem_read_exception, in_mem_write_exception,
        input  out_req_ready, out_resp_valid, out_resp_data, out_resp_exception,
               out_mem_read_address, out_mem_write_enable,
               out_mem_write_address, out_mem_write_data
    );
endinterface

// File: rtl/mem_lsu_lane.sv
// Byte-lane datapath: extracts and extends load lanes, and merges store
// lanes into a previously read word. Purely combinational.
module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [31:0] load_word,
    input  logic [31:0] merge_word,
    input  logic [31:0] store_data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Select the addressed lane of the read word and extend it to 32 bits.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        load_data = load_word;
        load_byte = load_word[{offset, 3'b000} +: 8];
        load_half = load_word[{offset[1], 4'b0000} +: 16];
        case (size)
            SIZE_B:  load_data = {{24{is_signed & load_byte[7]}}, load_byte};
            SIZE_H:  load_data = {{16{is_signed & load_half[15]}}, load_half};
            default: load_data = load_word;
        endcase
    end

    // Replace the addressed lane of the old word with right-aligned store data.
    always_comb begin
        merged_word = merge_word;
        case (size)
            SIZE_B:  merged_word[{offset, 3'b000} +: 8]     = store_data[7:0];
            SIZE_H:  merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/mem_lsu_adapter.sv
// Load/store adapter: turns byte/half/word requests into whole-word memory
// accesses, with read-modify-write for sub-word stores. One request is in
// flight at a time; this module holds the FSM and registers, the lane
// datapath lives in mem_lsu_lane.
module mem_lsu_adapter
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,   // only 32 is supported
    parameter bit WORD_BYPASS = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    mem_lsu_adapter_if.slave bus
);

    localparam logic [1:0] IDLE  = LSU_IDLE;
    localparam logic [1:0] READ  = LSU_READ;
    localparam logic [1:0] WRITE = LSU_WRITE;
    localparam logic [1:0] RESP  = LSU_RESP;

    logic [1:0]            state_q, state_d;
    lsu_req_t              req_q, req_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_exc_q, resp_exc_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic [31:0] lane_load_data;
    logic [31:0] lane_merged_word;

    mem_lsu_lane u_lane (
        .load_word   (bus.in_mem_read_data),
        .merge_word  (rdata_q),
        .store_data  (req_q.wdata),
        .size        (req_q.size),
        .offset      (req_q.offset),
        .is_signed   (req_q.is_signed),
        .load_data   (lane_load_data),
        .merged_word (lane_merged_word)
    );

    // Next-state logic: accept in IDLE, sample memory in READ/WRITE,
    // hold the response in RESP until the consumer takes it.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rdata_d     = rdata_q;
        resp_data_d = resp_data_q;
        resp_exc_d  = resp_exc_q;
        mem_addr_d  = mem_addr_q;

        case (state_q)
            IDLE: begin
                if (bus.in_req_valid) begin
                    req_d.write     = bus.in_req_write;
                    req_d.size      = bus.in_req_size;
                    req_d.is_signed = bus.in_req_signed;
                    req_d.offset    = bus.in_req_address[1:0];
                    req_d.wdata     = bus.in_req_data;
                    if (lsu_misaligned(bus.in_req_size, bus.in_req_address[1:0])) begin
                        // Rejected without touching memory; address keeps its old value.
                        resp_data_d = '0;
                        resp_exc_d  = 1'b1;
                        state_d     = RESP;
                    end else begin
                        mem_addr_d = bus.in_req_address & ~ADDR_WIDTH'(3);
                        if (WORD_BYPASS && bus.in_req_write && (bus.in_req_size == SIZE_W)) begin
                            state_d = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                rdata_d = bus.in_mem_read_data;
                if (bus.in_mem_read_exception) begin
                    resp_data_d = '0;
                    resp_exc_d  = 1'b1;
                    state_d     = RESP;
                end else if (req_q.write) begin
                    state_d = WRITE;
                end else begin
                    resp_data_d = lane_load_data;
                    resp_exc_d  = 1'b0;
                    state_d     = RESP;
                end
            end
            WRITE: begin
                resp_data_d = '0;
                resp_exc_d  = bus.in_mem_write_exception;
                state_d     = RESP;
            end
            default: begin
                if (bus.in_resp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rdata_q     <= '0;
            resp_data_q <= '0;
            resp_exc_q  <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed by the combinational block.
            state_q     <= state_d;
            req_q       <= req_d;
            rdata_q     <= rdata_d;
            resp_data_q <= resp_data_d;
            resp_exc_q  <= resp_exc_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // Strobes decode straight from the state register, so they are glitch
    // free and fall as soon as reset forces the state back to IDLE.
    assign bus.out_req_ready         = (state_q == IDLE);
    assign bus.out_resp_valid        = (state_q == RESP);
    assign bus.out_resp_data         = resp_data_q;
    assign bus.out_resp_exception    = resp_exc_q;
    assign bus.out_mem_write_enable  = (state_q == WRITE);
    assign bus.out_mem_read_address  = mem_addr_q;
    assign bus.out_mem_write_address = mem_addr_q;
    assign bus.out_mem_write_data    = lane_merged_word;

endmodule

// File: tb/tb_mem_lsu_adapter.sv
// Directed scoreboard bench for mem_lsu_adapter with a small word memory.
module tb_mem_lsu_adapter;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    always #5 CLK = ~CLK;

    mem_lsu_adapter_if bus ();

    mem_lsu_adapter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .WORD_BYPASS (1'b1)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    // Word memory model: combinational read, commit on the clock edge.
    logic [31:0] mem [0:1023];
    logic        poke_en = 1'b0;
    logic [31:0] poke_addr = '0;
    logic [31:0] poke_data = '0;
    int          strobe_cnt = 0;
    logic [31:0] last_wdata = '0;

    assign bus.in_mem_read_data = mem[bus.out_mem_read_address[11:2]];

    always @(posedge CLK) begin
        if (poke_en) begin
            mem[poke_addr[11:2]] <= poke_data;
        end else if (bus.out_mem_write_enable) begin
            mem[bus.out_mem_write_address[11:2]] <= bus.out_mem_write_data;
        end
        if (bus.out_mem_write_enable) begin
            strobe_cnt <= strobe_cnt + 1;
            last_wdata <= bus.out_mem_write_data;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        exc;
        int          lat;
        int          strobes;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLK);
        poke_en   = 1'b1;
        poke_addr = addr;
        poke_data = data;
        @(negedge CLK);
        poke_en   = 1'b0;
    endtask

    // One full transaction: push the expectation, drive and hand off the
    // request, wait for the response, then pop and compare.
    task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] edata, input logic eexc, input int elat,
                           input int estb, input int hold);
        exp_t e;
        int   cyc;
        int   strobes0;
        sb_q.push_back('{data: edata, exc: eexc, lat: elat, strobes: estb});
        @(negedge CLK);
        check({tag, ".req_ready"}, 32'(bus.out_req_ready), 32'd1);
        bus.in_req_valid   = 1'b1;
        bus.in_req_write   = wr;
        bus.in_req_size    = sz;
        bus.in_req_signed  = sg;
        bus.in_req_address = addr;
        bus.in_req_data    = wd;
        strobes0 = strobe_cnt;
        @(posedge CLK);
        #1 bus.in_req_valid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge CLK);
            cyc++;
            if (bus.out_resp_valid) break;
        end
        e = sb_q.pop_front();
        check({tag, ".resp_valid"}, 32'(bus.out_resp_valid), 32'd1);
        check({tag, ".latency"}, 32'(cyc), 32'(e.lat));
        check({tag, ".data"}, bus.out_resp_data, e.data);
        check({tag, ".exc"}, 32'(bus.out_resp_exception), 32'(e.exc));
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            check({tag, ".hold_valid"}, 32'(bus.out_resp_valid), 32'd1);
            check({tag, ".hold_data"}, bus.out_resp_data, e.data);
            check({tag, ".hold_ready"}, 32'(bus.out_req_ready), 32'd0);
        end
        bus.in_resp_ready = 1'b1;
        @(posedge CLK);
        #1 bus.in_resp_ready = 1'b0;
        check({tag, ".idle_ready"}, 32'(bus.out_req_ready), 32'd1);
        check({tag, ".idle_valid"}, 32'(bus.out_resp_valid), 32'd0);
        check({tag, ".strobes"}, 32'(strobe_cnt - strobes0), 32'(e.strobes));
    endtask

    initial begin
        int cyc;
        int strobes0;
        bus.in_req_valid           = 1'b0;
        bus.in_req_write           = 1'b0;
        bus.in_req_size            = 2'd0;
        bus.in_req_signed          = 1'b0;
        bus.in_req_address         = '0;
        bus.in_req_data            = '0;
        bus.in_resp_ready          = 1'b0;
        bus.in_mem_read_exception  = 1'b0;
        bus.in_mem_write_exception = 1'b0;

        // Reset values.
        repeat (2) @(negedge CLK);
        check("rst.resp_valid", 32'(bus.out_resp_valid), 32'd0);
        check("rst.we", 32'(bus.out_mem_write_enable), 32'd0);
        check("rst.resp_data", bus.out_resp_data, 32'd0);
        check("rst.resp_exc", 32'(bus.out_resp_exception), 32'd0);
        check("rst.rd_addr", bus.out_mem_read_address, 32'd0);
        check("rst.wr_addr", bus.out_mem_write_address, 32'd0);
        RESET_N = 1'b1;

        // Loads from word 0x100 = 0x88776655.
        poke(32'h100, 32'h8877_6655);
        run_req("lb_s_103", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'hFFFF_FF88, 1'b0, 2, 0, 0);
        run_req("lbu_100", 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 32'h0000_0055, 1'b0, 2, 0, 0);
        run_req("lhu_102", 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h0000_8877, 1'b0, 2, 0, 0);
        run_req("lh_s_102", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'hFFFF_8877, 1'b0, 2, 0, 0);
        run_req("lw_100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h8877_6655, 1'b0, 2, 0, 0);

        // Misaligned word load: exception, no access, address holds.
        run_req("lw_102", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        check("lw_102.addr_hold", bus.out_mem_read_address, 32'h100);

        // Sub-word stores by read-modify-write.
        poke(32'h100, 32'h1122_3344);
        run_req("sb_101", 1'b1, 2'd0, 1'b0, 32'h101, 32'hFFFF_FFAB, 32'h0, 1'b0, 3, 1, 0);
        check("sb_101.wdata", last_wdata, 32'h1122_AB44);
        check("sb_101.mem", mem[32'h100 >> 2], 32'h1122_AB44);
        run_req("sh_102", 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_1234, 32'h0, 1'b0, 3, 1, 0);
        check("sh_102.mem", mem[32'h100 >> 2], 32'h1234_AB44);

        // Bypassed word store: no READ state, latency 2.
        run_req("sw_200", 1'b1, 2'd2, 1'b0, 32'h200, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 0);
        check("sw_200.wdata", last_wdata, 32'hDEAD_BEEF);
        check("sw_200.mem", mem[32'h200 >> 2], 32'hDEAD_BEEF);

        // Illegal size and wrapped misaligned half.
        run_req("size3", 1'b0, 2'd3, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        run_req("lh_ffff", 1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        run_req("sh_odd", 1'b1, 2'd1, 1'b0, 32'h201, 32'h0000_5555, 32'h0, 1'b1, 1, 0, 0);

        // Memory-reported faults.
        bus.in_mem_read_exception = 1'b1;
        run_req("rd_fault", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 2, 0, 0);
        bus.in_mem_read_exception  = 1'b0;
        bus.in_mem_write_exception = 1'b1;
        run_req("wr_fault", 1'b1, 2'd0, 1'b0, 32'h204, 32'h0000_0077, 32'h0, 1'b1, 3, 1, 0);
        bus.in_mem_write_exception = 1'b0;

        // Response backpressure for 5 cycles.
        run_req("lw_hold", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, 5);

        // Reset during WRITE of a halfword store.
        poke(32'h300, 32'h55AA_55AA);
        @(negedge CLK);
        bus.in_req_valid   = 1'b1;
        bus.in_req_write   = 1'b1;
        bus.in_req_size    = 2'd1;
        bus.in_req_signed  = 1'b0;
        bus.in_req_address = 32'h300;
        bus.in_req_data    = 32'h0000_CAFE;
        strobes0 = strobe_cnt;
        @(posedge CLK);
        #1 bus.in_req_valid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge CLK);
            cyc++;
            if (bus.out_mem_write_enable) break;
        end
        check("rst_wr.we_seen", 32'(bus.out_mem_write_enable), 32'd1);
        RESET_N = 1'b0;
        #1;
        check("rst_wr.we_drop", 32'(bus.out_mem_write_enable), 32'd0);
        check("rst_wr.resp_valid", 32'(bus.out_resp_valid), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("rst_wr.mem", mem[32'h300 >> 2], 32'h55AA_55AA);
        check("rst_wr.strobes", 32'(strobe_cnt - strobes0), 32'd0);
        check("rst_wr.req_ready", 32'(bus.out_req_ready), 32'd1);
        check("rst_wr.no_resp", 32'(bus.out_resp_valid), 32'd0);
        run_req("lw_300", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h55AA_55AA, 1'b0, 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
